// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in/serial-out stage; streams WIDTH-bit words gaplessly.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic             r_out;
  logic             r_out_valid;
  logic             r_done;

  logic             w_accept;
  logic             w_load_bit;
  logic [WIDTH-1:0] w_load_rest;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_next_rest;

  // The shift register holds only the bits still to be sent after the one on out.
  if (LSB_FIRST) begin : g_lsb_first
    assign w_load_bit  = data_in[0];
    assign w_load_rest = data_in >> 1;
    assign w_next_bit  = r_shift[0];
    assign w_next_rest = r_shift >> 1;
  end else begin : g_msb_first
    assign w_load_bit  = data_in[WIDTH-1];
    assign w_load_rest = data_in << 1;
    assign w_next_bit  = r_shift[WIDTH-1];
    assign w_next_rest = r_shift << 1;
  end

  assign load_ready = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && (r_count == '0));
  assign w_accept   = load_valid && load_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_out       <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_SHIFT;
      r_count     <= c_LAST;
      r_shift     <= w_load_rest;
      r_out       <= w_load_bit;
      r_out_valid <= 1'b1;
      r_done      <= 1'b0;
    end else if ((r_state == ST_SHIFT) && (r_count != '0)) begin
      r_count     <= r_count - c_ONE;
      r_shift     <= w_next_rest;
      r_out       <= w_next_bit;
      r_out_valid <= 1'b1;
      r_done      <= (r_count == c_ONE);
    end else begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_shift     <= '0;
      r_out       <= IDLE_BIT;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Checks MSB-first and LSB-first serializers against a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;

  logic w_ready_m, w_out_m, w_valid_m, w_done_m;
  logic w_ready_l, w_out_l, w_valid_l, w_done_l;

  int checks = 0;
  int errors = 0;

  // Expected bits still to appear on out; element 0 is the bit on out now.
  logic q_msb[$];
  logic q_lsb[$];

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(w_ready_m), .out(w_out_m), .out_valid(w_valid_m), .done(w_done_m)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(w_ready_l), .out(w_out_l), .out_valid(w_valid_l), .done(w_done_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " msb.out"},        w_out_m,   (q_msb.size() > 0) ? q_msb[0] : 1'b0);
    check({tag, " msb.out_valid"},  w_valid_m, q_msb.size() > 0);
    check({tag, " msb.done"},       w_done_m,  q_msb.size() == 1);
    check({tag, " msb.load_ready"}, w_ready_m, q_msb.size() <= 1);
    check({tag, " lsb.out"},        w_out_l,   (q_lsb.size() > 0) ? q_lsb[0] : 1'b0);
    check({tag, " lsb.out_valid"},  w_valid_l, q_lsb.size() > 0);
    check({tag, " lsb.done"},       w_done_l,  q_lsb.size() == 1);
    check({tag, " lsb.load_ready"}, w_ready_l, q_lsb.size() <= 1);
  endtask

  // A word is accepted only when at most its predecessor's last bit remains.
  task automatic model_edge(input logic lv, input logic [7:0] d);
    logic acc;
    acc = lv && (q_msb.size() <= 1);
    if (q_msb.size() > 0) void'(q_msb.pop_front());
    if (q_lsb.size() > 0) void'(q_lsb.pop_front());
    if (acc) begin
      for (int i = 7; i >= 0; i--) q_msb.push_back(d[i]);
      for (int i = 0; i < 8; i++)  q_lsb.push_back(d[i]);
    end
  endtask

  task automatic step(input string tag, input logic lv, input logic [7:0] d);
    load_valid = lv;
    data_in    = d;
    @(posedge clk);
    model_edge(lv, d);
    #1;
    check_all(tag);
  endtask

  // Reset pulse placed between edges; outputs must drop before any clock edge.
  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    q_msb.delete();
    q_lsb.delete();
    check_all(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    data_in    = 8'h00;
    #2;
    check_all("in_reset");
    #20;
    reset = 1'b1;
    #1;
    check_all("after_release");
    repeat (2) step("idle_no_load", 1'b0, 8'h00);

    step("single_a8", 1'b1, 8'hA8);
    repeat (9) step("single_a8", 1'b0, 8'h00);

    step("b2b_a8", 1'b1, 8'hA8);
    repeat (7) step("b2b_a8", 1'b0, 8'h00);
    step("b2b_55", 1'b1, 8'h55);
    repeat (7) step("b2b_55", 1'b0, 8'h00);
    repeat (2) step("b2b_tail", 1'b0, 8'h00);

    step("midload_a8", 1'b1, 8'hA8);
    step("midload_a8", 1'b0, 8'h00);
    step("midload_ff", 1'b1, 8'hFF);
    repeat (7) step("midload_a8", 1'b0, 8'h00);

    step("lsb_15", 1'b1, 8'h15);
    repeat (8) step("lsb_15", 1'b0, 8'h00);

    step("rst_ff", 1'b1, 8'hFF);
    repeat (3) step("rst_ff", 1'b0, 8'h00);
    async_reset("async_reset");
    step("post_rst_a8", 1'b1, 8'hA8);
    repeat (9) step("post_rst_a8", 1'b0, 8'h00);

    for (int n = 0; n < 400; n++) begin
      step("random", ($urandom_range(0, 9) < 6), 8'($urandom));
      if ($urandom_range(0, 59) == 0) async_reset("random_reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
